// File: rtl/spi_byte_receiver_if.sv
// Pin bundle between an SPI master (the Pi side) and the byte receiver.
// The slave modport is the receiver's view; the master modport is the view of whatever drives the bus.
interface spi_byte_receiver_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
);
   logic                  i_sck;
   logic                  i_mosi;
   logic                  i_cs;
   logic                  o_miso;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_done;
   logic                  o_err;
   logic                  o_busy;
   logic [CNT_WIDTH-1:0]  o_byte_cnt;

   modport slave (
      input  i_sck,
      input  i_mosi,
      input  i_cs,
      output o_miso,
      output o_data,
      output o_done,
      output o_err,
      output o_busy,
      output o_byte_cnt
   );

   modport master (
      output i_sck,
      output i_mosi,
      output i_cs,
      input  o_miso,
      input  o_data,
      input  o_done,
      input  o_err,
      input  o_busy,
      input  o_byte_cnt
   );
endinterface

// File: rtl/spi_byte_receiver.sv
// SPI mode-0 slave front end: synchronises raw SCK/MOSI/CS, assembles MSB-first words,
// echoes the previously received word on MISO and flags frames aborted mid-word.
module spi_byte_receiver #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   spi_byte_receiver_if.slave bus
);
   localparam int                   BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0]        BIT_LAST = BW'(DATA_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   // Reset values of the synchronisers, ordered {cs, mosi, sck}: cs idles high.
   localparam logic [2:0]           SYNC_RST = 3'b100;

   typedef enum logic [1:0] {
      WAIT_IDLE,
      IDLE,
      ACTIVE
   } state_t;

   logic [2:0] raw_bits;
   logic [2:0] sync_bits;

   assign raw_bits = {bus.i_cs, bus.i_mosi, bus.i_sck};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         logic [SYNC_STAGES-1:0] chain_q;

         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               chain_q <= {SYNC_STAGES{SYNC_RST[gi]}};
            end else begin
               chain_q <= {chain_q[SYNC_STAGES-2:0], raw_bits[gi]};
            end
         end

         assign sync_bits[gi] = chain_q[SYNC_STAGES-1];
      end
   endgenerate

   logic sck_s;
   logic mosi_s;
   logic cs_s;

   assign {cs_s, mosi_s, sck_s} = sync_bits;

   logic                 sck_hist_q;
   logic                 cs_hist_q;
   logic [SYNC_STAGES:0] prime_q;

   // prime_q fills with ones after reset; once its top bit is set every synchroniser stage
   // and history FF holds a real sample rather than its reset value.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sck_hist_q <= 1'b0;
         cs_hist_q  <= 1'b1;
         prime_q    <= '0;
      end else begin
         sck_hist_q <= sck_s;
         cs_hist_q  <= cs_s;
         prime_q    <= {prime_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   logic sck_rise;
   logic sck_fall;
   logic cs_rise;
   logic cs_fall;
   logic primed;

   assign sck_rise = sck_s & ~sck_hist_q;
   assign sck_fall = ~sck_s & sck_hist_q;
   assign cs_rise  = cs_s & ~cs_hist_q;
   assign cs_fall  = ~cs_s & cs_hist_q;
   assign primed   = prime_q[SYNC_STAGES];

   state_t                state_q;
   logic [BW-1:0]         bit_cnt_q;
   logic [DATA_WIDTH-1:0] rx_shift_q;
   logic [DATA_WIDTH-1:0] tx_shift_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  done_q;
   logic                  err_q;
   logic                  busy_q;
   logic [CNT_WIDTH-1:0]  byte_cnt_q;
   logic [DATA_WIDTH-1:0] rx_shift_d;

   assign rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= WAIT_IDLE;
         bit_cnt_q  <= '0;
         rx_shift_q <= '0;
         tx_shift_q <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         byte_cnt_q <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            WAIT_IDLE: begin
               // A frame already under way when reset lifted is skipped until cs goes high.
               if (primed && cs_s) begin
                  state_q <= IDLE;
               end
            end
            IDLE: begin
               if (cs_fall) begin
                  state_q    <= ACTIVE;
                  busy_q     <= 1'b1;
                  bit_cnt_q  <= '0;
                  byte_cnt_q <= '0;
                  tx_shift_q <= data_q;
               end
            end
            ACTIVE: begin
               if (cs_rise) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  if (bit_cnt_q != '0) begin
                     err_q <= 1'b1;
                  end
               end else if (sck_rise) begin
                  rx_shift_q <= rx_shift_d;
                  if (bit_cnt_q == BIT_LAST) begin
                     data_q    <= rx_shift_d;
                     done_q    <= 1'b1;
                     bit_cnt_q <= '0;
                     if (byte_cnt_q != CNT_MAX) begin
                        byte_cnt_q <= byte_cnt_q + CNT_WIDTH'(1);
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BW'(1);
                  end
               end else if (sck_fall) begin
                  // bit_cnt of zero here means a word just finished: start echoing it.
                  if (bit_cnt_q != '0) begin
                     tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                  end else begin
                     tx_shift_q <= data_q;
                  end
               end
            end
            default: begin
               state_q <= WAIT_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_miso     = tx_shift_q[DATA_WIDTH-1] & busy_q;
   assign bus.o_data     = data_q;
   assign bus.o_done     = done_q;
   assign bus.o_err      = err_q;
   assign bus.o_busy     = busy_q;
   assign bus.o_byte_cnt = byte_cnt_q;
endmodule

// File: tb/tb_spi_byte_receiver.sv
// Bench for spi_byte_receiver: drives SPI frames as a master, queues each completed byte
// and compares it when o_done fires; echo, error, reset and saturation cases follow.
module tb_spi_byte_receiver;
   localparam int DW = 8;
   localparam int CW = 8;
   localparam int SS = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   spi_byte_receiver_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   spi_byte_receiver #(
      .DATA_WIDTH (DW),
      .SYNC_STAGES(SS),
      .CNT_WIDTH  (CW)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   int         checks    = 0;
   int         failures  = 0;
   int         cyc       = 0;
   int         lsb_cyc   = 0;
   int         done_seen = 0;
   int         err_seen  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] data_prev = 8'h00;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: samples 1 ns after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (rst) begin
            data_prev = bus.o_data;
         end else begin
            if (bus.o_done || bus.o_err) begin
               check_eq("done_err_excl", {31'b0, bus.o_done & bus.o_err}, 32'd0);
            end
            if (bus.o_done) begin
               done_seen++;
               check_eq("done_latency", {31'b0, ((cyc - lsb_cyc) >= SS + 1) && ((cyc - lsb_cyc) <= SS + 2)}, 32'd1);
               check_eq("sb_nonempty", {31'b0, exp_q.size() > 0}, 32'd1);
               if (exp_q.size() > 0) begin
                  check_eq("rx_byte", {24'b0, bus.o_data}, {24'b0, exp_q.pop_front()});
               end
            end else if (bus.o_data !== data_prev) begin
               check_eq("data_hold", {24'b0, bus.o_data}, {24'b0, data_prev});
            end
            if (bus.o_err) begin
               err_seen++;
            end
            data_prev = bus.o_data;
         end
      end
   end

   // Sends the top nbits of d MSB-first, sampling MISO just before each rising SCK.
   task automatic spi_bits(input logic [7:0] d, input int nbits, input int half, output logic [7:0] echo);
      echo = '0;
      for (int i = 0; i < nbits; i++) begin
         bus.i_mosi = d[7-i];
         repeat (half) @(negedge clk);
         echo[7-i] = bus.o_miso;
         if (i == 7) begin
            exp_q.push_back(d);
            lsb_cyc = cyc;
         end
         bus.i_sck = 1'b1;
         repeat (half) @(negedge clk);
         bus.i_sck = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic [7:0] echo_exp, input int half, input string tag);
      logic [7:0] echo;
      spi_bits(d, 8, half, echo);
      check_eq(tag, {24'b0, echo}, {24'b0, echo_exp});
   endtask

   task automatic cs_low();
      bus.i_cs = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_high(input int half);
      repeat (half) @(negedge clk);
      bus.i_cs = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_data"}, {24'b0, bus.o_data}, 32'd0);
      check_eq({tag, "_ctl"}, {28'b0, bus.o_done, bus.o_err, bus.o_busy, bus.o_miso}, 32'd0);
      check_eq({tag, "_bcnt"}, {24'b0, bus.o_byte_cnt}, 32'd0);
   endtask

   initial begin
      logic [7:0] echo;
      logic [7:0] prev;
      int         d0;
      int         e0;

      rst        = 1'b1;
      bus.i_sck  = 1'b0;
      bus.i_mosi = 1'b0;
      bus.i_cs   = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (6) @(negedge clk);

      // Single byte frame
      d0 = done_seen; e0 = err_seen;
      cs_low();
      check_eq("t1_busy_hi", {31'b0, bus.o_busy}, 32'd1);
      send_byte(8'h01, 8'h00, 4, "t1_echo");
      cs_high(4);
      check_eq("t1_done_cnt", done_seen - d0, 32'd1);
      check_eq("t1_err_cnt", err_seen - e0, 32'd0);
      check_eq("t1_data", {24'b0, bus.o_data}, 32'h01);
      check_eq("t1_bcnt", {24'b0, bus.o_byte_cnt}, 32'd1);
      check_eq("t1_busy_lo", {31'b0, bus.o_busy}, 32'd0);

      // Echo: frame ending 0x03, then 0xF1,0x02
      d0 = done_seen;
      cs_low();
      send_byte(8'h03, 8'h01, 4, "t2a_echo");
      cs_high(4);
      cs_low();
      send_byte(8'hF1, 8'h03, 4, "t2b_echo0");
      send_byte(8'h02, 8'hF1, 4, "t2b_echo1");
      cs_high(4);
      check_eq("t2_done_cnt", done_seen - d0, 32'd3);
      check_eq("t2_data", {24'b0, bus.o_data}, 32'h02);
      check_eq("t2_bcnt", {24'b0, bus.o_byte_cnt}, 32'd2);

      // Aborted frame after 5 bits
      d0 = done_seen; e0 = err_seen;
      cs_low();
      spi_bits(8'b1011_0000, 5, 4, echo);
      cs_high(4);
      check_eq("t3_err_cnt", err_seen - e0, 32'd1);
      check_eq("t3_done_cnt", done_seen - d0, 32'd0);
      check_eq("t3_data", {24'b0, bus.o_data}, 32'h02);

      // Reset in the middle of a frame
      d0 = done_seen; e0 = err_seen;
      cs_low();
      spi_bits(8'hA5, 4, 4, echo);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("t4_rst");
      rst = 1'b0;
      spi_bits(8'h5A, 4, 4, echo);
      cs_high(4);
      check_eq("t4_done_broken", done_seen - d0, 32'd0);
      check_eq("t4_err_broken", err_seen - e0, 32'd0);
      check_eq("t4_data_zero", {24'b0, bus.o_data}, 32'd0);
      cs_low();
      send_byte(8'hF3, 8'h00, 4, "t4_echo");
      cs_high(4);
      check_eq("t4_done_cnt", done_seen - d0, 32'd1);
      check_eq("t4_data", {24'b0, bus.o_data}, 32'hF3);

      // Long frame at minimum SCK half-period; byte count saturates
      d0 = done_seen;
      prev = 8'hF3;
      cs_low();
      for (int k = 0; k < 300; k++) begin
         send_byte(8'(k), prev, 3, "t5_echo");
         prev = 8'(k);
      end
      cs_high(3);
      check_eq("t5_done_cnt", done_seen - d0, 32'd300);
      check_eq("t5_bcnt_sat", {24'b0, bus.o_byte_cnt}, 32'd255);
      check_eq("t5_data", {24'b0, bus.o_data}, 32'h2B);

      // CS rises in the same cycle as the final SCK rise
      d0 = done_seen; e0 = err_seen;
      cs_low();
      spi_bits(8'h96, 7, 4, echo);
      bus.i_mosi = 1'b0;
      repeat (4) @(negedge clk);
      bus.i_sck = 1'b1;
      bus.i_cs  = 1'b1;
      repeat (4) @(negedge clk);
      bus.i_sck = 1'b0;
      repeat (8) @(negedge clk);
      check_eq("t6_err_cnt", err_seen - e0, 32'd1);
      check_eq("t6_done_cnt", done_seen - d0, 32'd0);
      check_eq("t6_data", {24'b0, bus.o_data}, 32'h2B);
      check_eq("t6_busy_lo", {31'b0, bus.o_busy}, 32'd0);

      repeat (10) @(negedge clk);
      check_eq("sb_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
